// File: rtl/step_driver_if.sv
// step_driver_if: burst request, downstream strobes and status for step_driver.
interface step_driver_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [CNT_W-1:0] step_count;
    logic [GAP_W-1:0] gap;
    logic             y_in;
    logic             x_out;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [1:0]       phase;
    logic [CNT_W-1:0] wraps;
    modport master (
        output start, step_count, gap, y_in,
        input  x_out, busy, done, mismatch, phase, wraps
    );
    modport slave (
        input  start, step_count, gap, y_in,
        output x_out, busy, done, mismatch, phase, wraps
    );
endinterface

// File: rtl/step_driver.sv
// step_driver: emits bursts of x strobes with programmable gaps and checks the
// downstream divide-by-4 FSM's y return against a mirrored copy of its state.
module step_driver #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input logic        CLK,
    input logic        RST,
    step_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] wraps_q, wraps_d;
    logic             mismatch_q, mismatch_d;
    logic             exp_y;
    assign exp_y = phase_q == 2'b11;
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        phase_d     = phase_q;
        wraps_d     = wraps_q;
        mismatch_d  = mismatch_q | (bus.y_in & (state_q != PULSE));
        case (state_q)
            IDLE: if (bus.start) begin
                mismatch_d = 1'b0;
                if (bus.step_count != '0) begin
                    remaining_d = bus.step_count;
                    gap_d       = bus.gap;
                    state_d     = PULSE;
                end else begin
                    state_d = DONE;
                end
            end
            PULSE: begin
                // downstream sequence 00->10->11->01 is a 2-bit Johnson step
                phase_d     = {~phase_q[0], phase_q[1]};
                remaining_d = remaining_q - CNT_W'(1);
                if (bus.y_in != exp_y) mismatch_d = 1'b1;
                if (bus.y_in && exp_y) wraps_d = wraps_q + CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = gap_q;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) state_d = PULSE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            phase_q     <= 2'b00;
            wraps_q     <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            phase_q     <= phase_d;
            wraps_q     <= wraps_d;
            mismatch_q  <= mismatch_d;
        end
    end
    assign bus.x_out    = state_q == PULSE;
    assign bus.busy     = (state_q == PULSE) || (state_q == GAP);
    assign bus.done     = state_q == DONE;
    assign bus.mismatch = mismatch_q;
    assign bus.phase    = phase_q;
    assign bus.wraps    = wraps_q;
endmodule

// File: tb/tb_step_driver.sv
// tb_step_driver: per-cycle expectations from a behavioural burst model are
// queued as stimulus is driven and compared when the DUT outputs settle.
module tb_step_driver;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;
    step_driver_if #(.CNT_W(8), .GAP_W(4)) bus ();
    step_driver #(.CNT_W(8), .GAP_W(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    typedef struct {
        logic       x;
        logic       b;
        logic       d;
        logic [1:0] ph;
        logic [7:0] wr;
        logic       mis;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic [1:0] m_phase = 2'b00;
    logic [7:0] m_wraps = 8'd0;
    logic       m_mis = 1'b0;
    int  cyc_n = 0;
    int  rst_at = -1;
    bit  aborted = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("x_out", 32'(bus.x_out), 32'(e.x));
            chk("busy", 32'(bus.busy), 32'(e.b));
            chk("done", 32'(bus.done), 32'(e.d));
            chk("phase", 32'(bus.phase), 32'(e.ph));
            chk("wraps", 32'(bus.wraps), 32'(e.wr));
            chk("mismatch", 32'(bus.mismatch), 32'(e.mis));
        end
    end
    task automatic tick(input logic x, input logic b, input logic d, input logic y,
                        input logic st, input logic [7:0] sc);
        exp_t e;
        logic r;
        if (aborted) return;
        r = cyc_n == rst_at;
        @(posedge CLK);
        #1;
        bus.start = st;
        bus.step_count = sc;
        bus.y_in = y;
        RST = r;
        e = '{x, b, d, m_phase, m_wraps, m_mis};
        q.push_back(e);
        cyc_n++;
        if (r) begin
            aborted = 1'b1;
            m_phase = 2'b00;
            m_wraps = 8'd0;
            m_mis   = 1'b0;
        end
    endtask
    task automatic burst(input int n, input int g, input int err_i, input int rst_c, input bit mid);
        logic ye, y;
        aborted = 1'b0;
        cyc_n = 0;
        rst_at = rst_c;
        bus.gap = 4'(g);
        tick(0, 0, 0, 0, 1, 8'(n));
        m_mis = 1'b0;
        for (int i = 0; i < n; i++) begin
            ye = m_phase == 2'b11;
            y = ye ^ (i == err_i);
            tick(1, 1, 0, y, 0, 8'(n));
            if (!aborted) begin
                if (y != ye) m_mis = 1'b1;
                if (y && ye) m_wraps = m_wraps + 8'd1;
                case (m_phase)
                    2'b00: m_phase = 2'b10;
                    2'b10: m_phase = 2'b11;
                    2'b11: m_phase = 2'b01;
                    default: m_phase = 2'b00;
                endcase
            end
            if (i < n - 1)
                for (int j = 0; j < g; j++) tick(0, 1, 0, 0, mid, 8'd7);
        end
        tick(0, 0, 1, 0, mid, 8'd7);
        tick(0, 0, 0, 0, 0, 8'd0);
        if (aborted) begin
            aborted = 1'b0;
            rst_at = -1;
            tick(0, 0, 0, 0, 0, 8'd0);
        end
        rst_at = -1;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.start = 1'b0;
        bus.step_count = 8'd0;
        bus.gap = 4'd0;
        bus.y_in = 1'b0;
        repeat (2) @(posedge CLK);
        tick(0, 0, 0, 0, 0, 8'd0);
        burst(4, 0, -1, -1, 0);
        burst(3, 2, -1, -1, 0);
        burst(0, 3, -1, -1, 0);
        burst(1, 0, -1, -1, 0);
        burst(4, 0, 2, -1, 0);
        burst(2, 1, -1, -1, 0);
        burst(200, 1, -1, 10, 1);
        burst(3, 1, -1, -1, 0);
        for (int k = 0; k < 5; k++) burst(200, 0, -1, -1, 0);
        burst(40, 0, -1, -1, 0);
        burst(5, 15, -1, -1, 1);
        repeat (3) @(negedge CLK);
        chk("drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
